kcpsm6_rgb_periph: RTL and testbench
====================================

# kcpsm6_rgb_periph

Parametrised KCPSM6 I/O peripheral: the next-generation port-mapped interface between the PicoBlaze and the display/colour datapath. It drives eight seven-segment digit codes and NUM_CH RGB channels of CW bits per component. Colour writes go to shadow registers and reach the outputs only on an atomic multi-channel commit. It adds pushbutton edge capture, a programmable periodic interrupt timer with enable and overrun status, and a readable status register.

## Interface
- NUM_CH, 2, number of RGB channels (1..7)
- CW, 4, bits per colour component (1..8)
- TICK_DEFAULT, 1000000, timer period (clocks) loaded at reset; 24-bit
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- db_btns  in  6  debounced buttons {center,left,up,right,down,cpureset}
- port_id  in  8  KCPSM6 port address
- out_port  in  8  KCPSM6 write data
- write_strobe, k_write_strobe  in  1 each  KCPSM6 write strobes (either one qualifies a write)
- read_strobe  in  1  KCPSM6 read strobe
- interrupt_ack  in  1  KCPSM6 interrupt acknowledge
- in_port  out  8  registered read data
- interrupt  out  1  interrupt request
- digits  out  40  {dig7..dig0}, 5 bits each
- rgb_out  out  3*CW*NUM_CH  channel k at [3*CW*(k+1)-1 : 3*CW*k], packed {R,G,B}

## Operation
- Address map (R = read, W = write):
  - 0x00 R: {3'b0, center, left, up, right, down}, live.
  - 0x01..0x08 W: dig7..dig0 <= out_port[4:0].
  - 0x09 R: {3'b0, edge latch[4:0]}; read clears the latch.
  - 0x0A+3k, +3k+1, +3k+2 W: shadow R/G/B of channel k <= out_port[CW-1:0]. Writes to addresses of channels >= NUM_CH are ignored.
  - 0x20 W: commit mask. For each bit k < NUM_CH set, active[k] <= shadow[k], all in the same cycle. A mask of 0 is a no-op.
  - 0x21/0x22/0x23 W/R: timer period bytes [7:0]/[15:8]/[23:16]. Any write also clears the timer counter.
  - 0x24 W/R: control {6'b0, irq_en, tmr_en}. Reset value 2'b11.
  - 0x25 R: status {6'b0, overrun, interrupt}. W: writing 1 to bit1 clears overrun.
  - Unmapped read addresses return 0x00. Unmapped writes are ignored.
- Edge latch: a bit sets on a 0->1 transition of its button, using a registered previous sample. cpureset is not latched.
- Timer: a 24-bit counter runs when tmr_en=1 and period != 0.
  - When counter == period: one-cycle tick, counter <= 0; otherwise counter increments.
  - Tick period is period+1 clocks.
  - tmr_en=0 or period=0: the counter holds at 0 and no ticks occur.
- Interrupt:
  - Priority: tick && irq_en sets interrupt; otherwise interrupt_ack clears it; otherwise it holds.
  - If tick && irq_en while interrupt=1 and interrupt_ack=0, overrun is set (sticky).
- Reset:
  - in_port=0, interrupt=0, digits=0, rgb_out=0.
  - Shadows=0, edge latch=0, overrun=0.
  - period=TICK_DEFAULT, control=2'b11, counter=0.
  - Previous-button register loads the current db_btns, so no spurious edge is captured on the first cycle after reset.

## Timing
- Writes take effect on the clk edge where a write strobe is high. digits, shadows and control are visible the next cycle.
- Commit: rgb_out changes exactly 1 cycle after the 0x20 write, for all masked channels simultaneously.
- Shadow write and commit to the same channel in different cycles: the commit uses the value present at the commit edge.
- in_port updates every cycle from port_id (1-cycle latency), independent of read_strobe. This meets KCPSM6's 2-cycle INPUT timing.
- Read-clear of 0x09 occurs on the read_strobe cycle.
  - An edge arriving in that same cycle sets its bit (set beats clear).
  - The read value is the pre-clear value.
- Simultaneous tick and interrupt_ack: interrupt stays 1, overrun is not set.
- A period write in the same cycle as a tick: the write wins, counter <= 0, and the tick is still honoured for the interrupt.
- Reset mid-operation: all state returns to its reset values on the next edge, and a pending interrupt is dropped.

## Test plan
- Reset, then read 0x24, 0x21..0x23 -> 0x03, then 0x40/0x42/0x0F (TICK_DEFAULT=1000000); rgb_out=0, interrupt=0.
- Write shadows for ch0 = (0xA,0x5,0x3) and ch1 = (0x1,0x2,0x4) without commit -> rgb_out unchanged. Write 0x20 = 0x01 -> only ch0 = 0xA53 the next cycle. Write 0x20 = 0x02 -> ch1 = 0x124.
- Set period 0x000009 -> interrupt asserts every 10 clocks. Ack within 3 cycles -> overrun stays 0. Withhold ack across 2 ticks -> status reads 0x03. Write 0x25 = 0x02 -> status 0x01.
- Pulse up (db_btns[3]) 0->1, then read 0x09 -> 0x04; a second read -> 0x00. An edge on left coincident with the read strobe -> the next read returns 0x08.
- Tick and interrupt_ack in the same cycle -> interrupt remains 1. Control = 0x01 (irq_en=0) -> ticks continue, interrupt never sets.
- Write 0x01..0x08 with 0x11..0x18 -> digits = {5'h11,...,5'h18}. Assert reset mid-sequence -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/kcpsm6_rgb_periph.sv
// KCPSM6 port-mapped peripheral: seven-segment digit codes, shadowed RGB channels
// with atomic commit, button edge capture, periodic interrupt timer and status.

module kcpsm6_rgb_chan #(
   parameter int CW = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [2:0]      wr,      // one-hot {R,G,B} shadow write
   input  logic [CW-1:0]   wdata,
   input  logic            commit,
   output logic [3*CW-1:0] rgb
);
   logic [2:0][CW-1:0] shadow;

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow <= '0;
         rgb    <= '0;
      end else begin
         for (int c = 0; c < 3; c++)
            if (wr[c]) shadow[c] <= wdata;
         // commit samples the shadow as it stands at this edge
         if (commit) rgb <= shadow;
      end
   end
endmodule

module kcpsm6_rgb_periph #(
   parameter int NUM_CH       = 2,
   parameter int CW           = 4,
   parameter int TICK_DEFAULT = 1000000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [5:0]               db_btns,
   input  logic [7:0]               port_id,
   input  logic [7:0]               out_port,
   input  logic                     write_strobe,
   input  logic                     k_write_strobe,
   input  logic                     read_strobe,
   input  logic                     interrupt_ack,
   output logic [7:0]               in_port,
   output logic                     interrupt,
   output logic [39:0]              digits,
   output logic [3*CW*NUM_CH-1:0]   rgb_out
);
   localparam logic [23:0] TICK_INIT = 24'(TICK_DEFAULT);

   logic                          wr;
   logic [7:0][4:0]               dig;
   logic [4:0]                    prev_btns, edge_lat, rises;
   logic                          rd_edges;
   logic [23:0]                   period, count;
   logic [1:0]                    ctrl;
   logic                          overrun;
   logic                          run, tick, irq_fire, per_wr;
   logic [7:0]                    rd_data;
   logic [NUM_CH-1:0][2:0]        sh_wr;
   logic [NUM_CH-1:0]             commit;
   logic [NUM_CH-1:0][3*CW-1:0]   ch_rgb;
   logic                          unused_cpureset;

   assign wr              = write_strobe | k_write_strobe;
   assign unused_cpureset = db_btns[0];
   assign digits          = dig;
   assign rgb_out         = ch_rgb;

   assign rises    = db_btns[5:1] & ~prev_btns;
   assign rd_edges = read_strobe && (port_id == 8'h09);

   assign run      = ctrl[0] && (period != '0);
   assign tick     = run && (count == period);
   assign irq_fire = tick && ctrl[1];
   assign per_wr   = wr && (port_id == 8'h21 || port_id == 8'h22 || port_id == 8'h23);

   genvar k, c;
   generate
      for (k = 0; k < NUM_CH; k++) begin : g_ch
         for (c = 0; c < 3; c++) begin : g_comp
            assign sh_wr[k][2-c] = wr && (port_id == 8'(10 + 3*k + c));
         end
         assign commit[k] = wr && (port_id == 8'h20) && out_port[k];

         kcpsm6_rgb_chan #(.CW(CW)) u_chan (
            .clk    (clk),
            .reset  (reset),
            .wr     (sh_wr[k]),
            .wdata  (out_port[CW-1:0]),
            .commit (commit[k]),
            .rgb    (ch_rgb[k])
         );
      end
   endgenerate

   always_comb begin
      rd_data = 8'h00;
      case (port_id)
         8'h00:   rd_data = {3'b0, db_btns[5:1]};
         8'h09:   rd_data = {3'b0, edge_lat};
         8'h21:   rd_data = period[7:0];
         8'h22:   rd_data = period[15:8];
         8'h23:   rd_data = period[23:16];
         8'h24:   rd_data = {6'b0, ctrl};
         8'h25:   rd_data = {6'b0, overrun, interrupt};
         default: rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_port   <= '0;
         dig       <= '0;
         prev_btns <= db_btns[5:1];
         edge_lat  <= '0;
      end else begin
         in_port   <= rd_data;
         prev_btns <= db_btns[5:1];
         // a new edge in the read-clear cycle survives the clear
         edge_lat  <= (rd_edges ? 5'b0 : edge_lat) | rises;
         for (int i = 0; i < 8; i++)
            if (wr && port_id == 8'(8 - i)) dig[i] <= out_port[4:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         period    <= TICK_INIT;
         ctrl      <= 2'b11;
         count     <= '0;
         interrupt <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (wr && port_id == 8'h21) period[7:0]   <= out_port;
         if (wr && port_id == 8'h22) period[15:8]  <= out_port;
         if (wr && port_id == 8'h23) period[23:16] <= out_port;
         if (wr && port_id == 8'h24) ctrl          <= out_port[1:0];

         if (per_wr || !run || tick) count <= '0;
         else                        count <= count + 24'd1;

         if (irq_fire)           interrupt <= 1'b1;
         else if (interrupt_ack) interrupt <= 1'b0;

         overrun <= (irq_fire && interrupt && !interrupt_ack) |
                    (overrun && !(wr && port_id == 8'h25 && out_port[1]));
      end
   end
endmodule

// File: tb/tb_kcpsm6_rgb_periph.sv
// Directed plus randomized bench for kcpsm6_rgb_periph against a register-map model.

module tb_kcpsm6_rgb_periph;
   localparam int NUM_CH = 2;
   localparam int CW     = 4;
   localparam int RW     = 3*CW*NUM_CH;

   logic          clk = 1'b0;
   logic          reset;
   logic [5:0]    db_btns;
   logic [7:0]    port_id, out_port;
   logic          write_strobe, k_write_strobe, read_strobe, interrupt_ack;
   logic [7:0]    in_port;
   logic          interrupt;
   logic [39:0]   digits;
   logic [RW-1:0] rgb_out;

   int checks = 0;
   int errors = 0;

   // model state
   logic [4:0] mdig [8];
   logic [7:0] msh  [7][3];
   logic [7:0] mact [7][3];
   logic [4:0] mlat;
   logic [5:0] cur_btns;

   logic [7:0]    rdat, a, d;
   logic [5:0]    nb;
   logic [4:0]    rs;
   logic [39:0]   edig;
   logic [RW-1:0] ergb;
   int            n, highs, op;

   kcpsm6_rgb_periph #(.NUM_CH(NUM_CH), .CW(CW), .TICK_DEFAULT(1000000)) dut (
      .clk            (clk),
      .reset          (reset),
      .db_btns        (db_btns),
      .port_id        (port_id),
      .out_port       (out_port),
      .write_strobe   (write_strobe),
      .k_write_strobe (k_write_strobe),
      .read_strobe    (read_strobe),
      .interrupt_ack  (interrupt_ack),
      .in_port        (in_port),
      .interrupt      (interrupt),
      .digits         (digits),
      .rgb_out        (rgb_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      port_id  = addr;
      out_port = data;
      if ($urandom_range(0, 1) == 1) write_strobe = 1'b1;
      else                           k_write_strobe = 1'b1;
      step();
      write_strobe   = 1'b0;
      k_write_strobe = 1'b0;
   endtask

   task automatic rd(input logic [7:0] addr, output logic [7:0] data);
      port_id     = addr;
      read_strobe = 1'b1;
      step();
      read_strobe = 1'b0;
      data        = in_port;
   endtask

   task automatic ack();
      interrupt_ack = 1'b1;
      step();
      interrupt_ack = 1'b0;
   endtask

   task automatic wait_irq(input int max, output int cnt);
      cnt = 0;
      while (interrupt !== 1'b1 && cnt < max) begin
         step();
         cnt++;
      end
   endtask

   function automatic logic [39:0] exp_digits();
      logic [39:0] e = '0;
      for (int i = 7; i >= 0; i--) e = {e[34:0], mdig[i]};
      return e;
   endfunction

   function automatic logic [RW-1:0] exp_rgb();
      logic [RW-1:0] e = '0;
      for (int k = 0; k < NUM_CH; k++)
         e[3*CW*k +: 3*CW] = {mact[k][0][CW-1:0], mact[k][1][CW-1:0], mact[k][2][CW-1:0]};
      return e;
   endfunction

   initial begin
      for (int i = 0; i < 8; i++) mdig[i] = '0;
      for (int k = 0; k < 7; k++)
         for (int c = 0; c < 3; c++) begin
            msh[k][c]  = '0;
            mact[k][c] = '0;
         end
      mlat = '0;
      reset = 1'b1; port_id = 8'h00; out_port = 8'h00;
      write_strobe = 1'b0; k_write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
      db_btns = 6'b101010;   // held through reset: must not latch as edges
      cur_btns = db_btns;
      step(); step();
      check("rst_in_port", in_port, 0);
      check("rst_irq", interrupt, 0);
      check("rst_digits", digits, 0);
      check("rst_rgb", rgb_out, 0);
      reset = 1'b0;

      rd(8'h09, rdat); check("no_edge_after_reset", rdat, 8'h00);
      rd(8'h24, rdat); check("ctrl_reset", rdat, 8'h03);
      rd(8'h21, rdat); check("period_b0", rdat, 8'h40);
      rd(8'h22, rdat); check("period_b1", rdat, 8'h42);
      rd(8'h23, rdat); check("period_b2", rdat, 8'h0F);
      db_btns = 6'b0; cur_btns = 6'b0;
      step();

      // shadow + commit
      wr(8'h0A, 8'hFA); wr(8'h0B, 8'h05); wr(8'h0C, 8'h03);
      wr(8'h0D, 8'h01); wr(8'h0E, 8'h02); wr(8'h0F, 8'h04);
      check("shadow_no_commit", rgb_out, 0);
      wr(8'h20, 8'h00); check("commit_mask0", rgb_out, 0);
      wr(8'h20, 8'h01); check("commit_ch0", rgb_out, 24'h000A53);
      wr(8'h20, 8'h02); check("commit_ch1", rgb_out, 24'h124A53);
      mact[0][0] = 8'hA; mact[0][1] = 8'h5; mact[0][2] = 8'h3;
      mact[1][0] = 8'h1; mact[1][1] = 8'h2; mact[1][2] = 8'h4;
      for (int c = 0; c < 3; c++) begin
         msh[0][c] = mact[0][c];
         msh[1][c] = mact[1][c];
      end

      // digits
      for (int i = 1; i <= 8; i++) begin
         wr(8'(i), 8'(8'h10 + i));
         mdig[8-i] = 5'(8'h10 + i);
      end
      check("digits_seq", digits, {5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h18});

      // timer: period 9 -> interrupt every 10 clocks
      wr(8'h21, 8'h09); wr(8'h22, 8'h00); wr(8'h23, 8'h00);
      wait_irq(50, n); check("first_tick_latency", n, 10);
      ack(); check("ack_clears", interrupt, 0);
      wait_irq(50, n); check("tick_period", n + 1, 10);
      rd(8'h25, rdat); check("status_no_overrun", rdat, 8'h01);
      for (int i = 0; i < 20; i++) step();
      rd(8'h25, rdat); check("status_overrun", rdat, 8'h03);
      wr(8'h25, 8'h02);
      rd(8'h25, rdat); check("status_overrun_clr", rdat, 8'h01);

      // ack coincident with a tick: interrupt must stay set, no overrun
      ack();
      wait_irq(50, n); check("rise_before_coinc", interrupt, 1);
      for (int i = 0; i < 9; i++) step();
      ack(); check("tick_beats_ack", interrupt, 1);
      rd(8'h25, rdat); check("coinc_no_overrun", rdat, 8'h01);

      // irq_en=0: ticks keep running, interrupt stays low
      wr(8'h24, 8'h01); ack();
      highs = 0;
      for (int i = 0; i < 35; i++) begin step(); if (interrupt) highs++; end
      check("irq_masked", highs, 0);
      wr(8'h24, 8'h03);
      wait_irq(12, n); check("ticks_continued", interrupt, 1);
      wr(8'h24, 8'h00); ack();
      rd(8'h25, rdat); check("status_idle", rdat, 8'h00);

      // tmr_en=0 and period=0 both stop the timer
      wr(8'h24, 8'h02);
      highs = 0;
      for (int i = 0; i < 30; i++) begin step(); if (interrupt) highs++; end
      check("tmr_disabled", highs, 0);
      wr(8'h21, 8'h00); wr(8'h24, 8'h03);
      highs = 0;
      for (int i = 0; i < 30; i++) begin step(); if (interrupt) highs++; end
      check("period_zero", highs, 0);
      wr(8'h24, 8'h00);

      // directed edge capture
      db_btns = 6'b001000; step(); db_btns = 6'b0; step();
      rd(8'h09, rdat); check("edge_up", rdat, 8'h04);
      rd(8'h09, rdat); check("edge_cleared", rdat, 8'h00);
      db_btns = 6'b010000;
      rd(8'h09, rdat); check("edge_coinc_read", rdat, 8'h00);
      rd(8'h09, rdat); check("edge_set_beats_clr", rdat, 8'h08);
      db_btns = 6'b0; cur_btns = 6'b0; mlat = '0;
      step();

      // randomized register traffic against the model
      for (int t = 0; t < 300; t++) begin
         nb = ($urandom_range(0, 3) == 0) ? 6'($urandom) : cur_btns;
         rs = nb[5:1] & ~cur_btns[5:1];
         db_btns = nb;
         op = $urandom_range(0, 5);
         d = 8'($urandom);
         case (op)
            0: begin
               a = 8'($urandom_range(1, 8));
               wr(a, d);
               mdig[8 - a] = d[4:0];
            end
            1: begin
               a = 8'($urandom_range(8'h0A, 8'h1E));
               wr(a, d);
               if ((a - 8'h0A) / 3 < NUM_CH) msh[(a - 8'h0A) / 3][(a - 8'h0A) % 3] = 8'(d[CW-1:0]);
            end
            2: begin
               wr(8'h20, d);
               for (int k = 0; k < NUM_CH; k++)
                  if (d[k]) for (int c = 0; c < 3; c++) mact[k][c] = msh[k][c];
            end
            3: begin
               rd(8'h09, rdat);
               check("rand_edges", rdat, {3'b0, mlat});
            end
            4: begin
               rd(8'h00, rdat);
               check("rand_btns", rdat, {3'b0, nb[5:1]});
            end
            default: begin
               case ($urandom_range(0, 3))
                  0: a = 8'h00;
                  1: a = 8'h1F;
                  2: a = 8'h30;
                  default: a = 8'hFF;
               endcase
               wr(a, d);
            end
         endcase
         mlat = (op == 3) ? rs : (mlat | rs);
         cur_btns = nb;
         edig = exp_digits();
         ergb = exp_rgb();
         check("rand_digits", digits, edig);
         check("rand_rgb", rgb_out, ergb);
      end

      // reset in the middle of activity drops everything
      wr(8'h01, 8'h1F); wr(8'h0A, 8'h0F); wr(8'h20, 8'h01);
      wr(8'h21, 8'h04); wr(8'h24, 8'h03);
      wait_irq(30, n); check("irq_before_reset", interrupt, 1);
      rd(8'h24, rdat);
      reset = 1'b1; step();
      check("mid_rst_digits", digits, 0);
      check("mid_rst_rgb", rgb_out, 0);
      check("mid_rst_irq", interrupt, 0);
      check("mid_rst_in_port", in_port, 0);
      reset = 1'b0;
      rd(8'h21, rdat); check("mid_rst_period", rdat, 8'h40);
      rd(8'h24, rdat); check("mid_rst_ctrl", rdat, 8'h03);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
